// File: rtl/tetris_timing_pkg.sv
// rtl/tetris_timing_pkg.sv - state encoding, default timing constants and drop interval helper
package tetris_timing_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FALL   = 2'd1,
        LOCK   = 2'd2,
        PAUSED = 2'd3
    } state_t;

    localparam int DEF_CLK_PER_MS       = 100_000;
    localparam int DEF_BASE_INTERVAL_MS = 1000;
    localparam int DEF_STEP_MS          = 50;
    localparam int DEF_MIN_INTERVAL_MS  = 100;
    localparam int DEF_SOFT_INTERVAL_MS = 50;
    localparam int DEF_LOCK_DELAY_MS    = 500;
    localparam int DEF_MAX_RESETS       = 15;

    // Signed 16-bit so high levels go negative and clamp to the floor.
    function automatic logic [15:0] calc_interval(input logic [4:0] level,
                                                  input int base_ms,
                                                  input int step_ms,
                                                  input int min_ms);
        logic signed [15:0] iv;
        iv = $signed(16'(base_ms)) - $signed(16'(level)) * $signed(16'(step_ms));
        if (iv < $signed(16'(min_ms)))
            return 16'(min_ms);
        return $unsigned(iv);
    endfunction

endpackage

// File: rtl/tetris_drop_scheduler_ms_prescaler.sv
// rtl/tetris_drop_scheduler_ms_prescaler.sv - 1 ms base tick divider, frozen while paused
module ms_prescaler #(
    parameter int CLK_PER_MS = 100_000
) (
    input  logic clk100M,
    input  logic rst,
    input  logic pause,
    output logic ms_tick
);

    localparam int W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic [W-1:0] cnt;

    assign ms_tick = !pause && (cnt == W'(CLK_PER_MS - 1));

    always_ff @(posedge clk100M) begin
        if (rst)
            cnt <= '0;
        else if (!pause)
            cnt <= ms_tick ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/tetris_drop_scheduler.sv
// rtl/tetris_drop_scheduler.sv - gravity/lock timing FSM; TETRIS_SOFT_DROP_EN enables the soft-drop interval
module tetris_drop_scheduler
    import tetris_timing_pkg::*;
#(
    parameter int CLK_PER_MS       = DEF_CLK_PER_MS,
    parameter int BASE_INTERVAL_MS = DEF_BASE_INTERVAL_MS,
    parameter int STEP_MS          = DEF_STEP_MS,
    parameter int MIN_INTERVAL_MS  = DEF_MIN_INTERVAL_MS,
    parameter int SOFT_INTERVAL_MS = DEF_SOFT_INTERVAL_MS,
    parameter int LOCK_DELAY_MS    = DEF_LOCK_DELAY_MS,
    parameter int MAX_RESETS       = DEF_MAX_RESETS
) (
    input  logic       clk100M,
    input  logic       rst,
    input  logic [4:0] level,
    input  logic       spawn,
    input  logic       grounded,
    input  logic       move_reset,
    input  logic       soft_drop,
    input  logic       pause,
    output logic       drop_pulse,
    output logic       lock_pulse,
    output logic [1:0] state_o
);

    logic        ms_tick;
    state_t      state, state_d, saved, saved_d, eff_state;
    logic [15:0] ms_cnt, ms_cnt_d, interval, lvl_interval;
    logic [7:0]  reset_cnt, reset_cnt_d;
    logic        drop_d, lock_d;

    ms_prescaler #(.CLK_PER_MS(CLK_PER_MS)) u_prescaler (
        .clk100M (clk100M),
        .rst     (rst),
        .pause   (pause),
        .ms_tick (ms_tick)
    );

    assign lvl_interval = calc_interval(level, BASE_INTERVAL_MS, STEP_MS, MIN_INTERVAL_MS);

`ifdef TETRIS_SOFT_DROP_EN
    assign interval = (soft_drop && (lvl_interval > 16'(SOFT_INTERVAL_MS)))
                    ? 16'(SOFT_INTERVAL_MS) : lvl_interval;
`else
    logic unused_soft_drop;
    assign unused_soft_drop = soft_drop;
    assign interval         = lvl_interval;
`endif

    always_comb begin
        state_d     = state;
        saved_d     = saved;
        ms_cnt_d    = ms_cnt;
        reset_cnt_d = reset_cnt;
        drop_d      = 1'b0;
        lock_d      = 1'b0;
        // On the release cycle the saved state runs normally so no tick is lost.
        eff_state   = (state == PAUSED) ? saved : state;

        if (pause) begin
            state_d = PAUSED;
            saved_d = eff_state;
        end else begin
            state_d = eff_state;
            if (spawn && (state != PAUSED)) begin
                state_d     = FALL;
                ms_cnt_d    = '0;
                reset_cnt_d = '0;
            end else begin
                case (eff_state)
                    FALL: begin
                        if (grounded) begin
                            state_d  = LOCK;
                            ms_cnt_d = '0;
                        end else if (ms_tick) begin
                            if ((ms_cnt + 16'd1) >= interval) begin
                                drop_d   = 1'b1;
                                ms_cnt_d = '0;
                            end else begin
                                ms_cnt_d = ms_cnt + 16'd1;
                            end
                        end
                    end
                    LOCK: begin
                        if (!grounded) begin
                            state_d  = FALL;
                            ms_cnt_d = '0;
                        end else if (move_reset && (reset_cnt < 8'(MAX_RESETS))) begin
                            ms_cnt_d    = '0;
                            reset_cnt_d = reset_cnt + 8'd1;
                        end else if (ms_tick) begin
                            if ((ms_cnt + 16'd1) >= 16'(LOCK_DELAY_MS)) begin
                                lock_d   = 1'b1;
                                state_d  = IDLE;
                                ms_cnt_d = '0;
                            end else begin
                                ms_cnt_d = ms_cnt + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk100M) begin
        if (rst) begin
            state      <= IDLE;
            saved      <= IDLE;
            ms_cnt     <= '0;
            reset_cnt  <= '0;
            drop_pulse <= 1'b0;
            lock_pulse <= 1'b0;
        end else begin
            state      <= state_d;
            saved      <= saved_d;
            ms_cnt     <= ms_cnt_d;
            reset_cnt  <= reset_cnt_d;
            drop_pulse <= drop_d;
            lock_pulse <= lock_d;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_tetris_drop_scheduler.sv
// tb/tb_tetris_drop_scheduler.sv - directed scoreboard bench for tetris_drop_scheduler
module tb_tetris_drop_scheduler;

    logic       clk100M = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] level = 5'd0;
    logic       spawn = 1'b0, grounded = 1'b0, move_reset = 1'b0;
    logic       soft_drop = 1'b0, pause = 1'b0;
    logic       drop_pulse, lock_pulse;
    logic [1:0] state_o;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int t0 = 0;
    int soft_period;
    bit sb_en = 1'b0;

    typedef struct {
        logic lock;
        int   cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk100M = ~clk100M;
    always @(posedge clk100M) cyc <= cyc + 1;

    tetris_drop_scheduler #(
        .CLK_PER_MS(4), .BASE_INTERVAL_MS(10), .STEP_MS(2), .MIN_INTERVAL_MS(3),
        .SOFT_INTERVAL_MS(1), .LOCK_DELAY_MS(5), .MAX_RESETS(2)
    ) dut (
        .clk100M    (clk100M),
        .rst        (rst),
        .level      (level),
        .spawn      (spawn),
        .grounded   (grounded),
        .move_reset (move_reset),
        .soft_drop  (soft_drop),
        .pause      (pause),
        .drop_pulse (drop_pulse),
        .lock_pulse (lock_pulse),
        .state_o    (state_o)
    );

    always @(negedge clk100M) begin
        if (drop_pulse || lock_pulse) begin
            tests++;
            assert (!(drop_pulse && lock_pulse)) else begin
                failed++;
                $error("FAIL both_pulses observed drop=%0b lock=%0b expected one-hot at cycle %0d",
                       drop_pulse, lock_pulse, cyc);
            end
        end
        if (sb_en && (drop_pulse || lock_pulse)) begin
            tests++;
            if (exp_q.size() > 0) mon_e = exp_q.pop_front();
            else begin
                mon_e.lock = 1'b0;
                mon_e.cyc  = -1;
            end
            assert ({lock_pulse, cyc} === {mon_e.lock, mon_e.cyc}) else begin
                failed++;
                $error("FAIL pulse_sb observed lock=%0b cycle=%0d expected lock=%0b cycle=%0d",
                       lock_pulse, cyc, mon_e.lock, mon_e.cyc);
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk100M);
    endtask

    task automatic wait_drop(input string tag);
        int n;
        sb_en = 1'b0;
        n = 0;
        do begin
            @(negedge clk100M);
            n++;
        end while (!drop_pulse && n < 300);
        check(tag, int'(drop_pulse), 1);
        t0 = cyc;
    endtask

    task automatic push(input logic lk, input int c);
        exp_t e;
        e.lock = lk;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic arm();
        @(posedge clk100M);
        sb_en = 1'b1;
    endtask

    task automatic do_spawn();
        @(negedge clk100M) spawn = 1'b1;
        @(negedge clk100M) spawn = 1'b0;
    endtask

    task automatic strobe_reset_at(input int c);
        wait_to(c);
        move_reset = 1'b1;
        @(negedge clk100M) move_reset = 1'b0;
    endtask

    initial begin
`ifdef TETRIS_SOFT_DROP_EN
        soft_period = 4;
`else
        soft_period = 40;
`endif
        repeat (3) @(negedge clk100M);
        check("rst_state", int'(state_o), 0);
        check("rst_drop", int'(drop_pulse), 0);
        check("rst_lock", int'(lock_pulse), 0);
        rst = 1'b0;

        do_spawn();
        check("spawn_state", int'(state_o), 1);

        wait_drop("sync_l0");
        for (int i = 1; i <= 3; i++) push(1'b0, t0 + 40 * i);
        arm();
        wait_to(t0 + 125);
        check("q_l0", exp_q.size(), 0);

        wait_drop("sync_respawn");
        push(1'b0, t0 + 60);
        arm();
        wait_to(t0 + 20);
        spawn = 1'b1;
        @(negedge clk100M) spawn = 1'b0;
        wait_to(t0 + 65);
        check("q_respawn", exp_q.size(), 0);

        level = 5'd31;
        wait_drop("sync_l31");
        for (int i = 1; i <= 3; i++) push(1'b0, t0 + 12 * i);
        arm();
        wait_to(t0 + 40);
        check("q_l31", exp_q.size(), 0);

        level = 5'd3;
        wait_drop("sync_l3");
        for (int i = 1; i <= 3; i++) push(1'b0, t0 + 16 * i);
        arm();
        wait_to(t0 + 52);
        check("q_l3", exp_q.size(), 0);

        level = 5'd0;
        soft_drop = 1'b1;
        wait_drop("sync_soft");
        for (int i = 1; i <= 3; i++) push(1'b0, t0 + soft_period * i);
        arm();
        wait_to(t0 + 3 * soft_period + 5);
        check("q_soft", exp_q.size(), 0);
        soft_drop = 1'b0;

        wait_drop("sync_pause");
        push(1'b0, t0 + 140);
        arm();
        wait_to(t0 + 10);
        pause = 1'b1;
        wait_to(t0 + 50);
        check("pause_state", int'(state_o), 3);
        wait_to(t0 + 110);
        pause = 1'b0;
        wait_to(t0 + 145);
        check("q_pause", exp_q.size(), 0);

        wait_drop("sync_lock");
        grounded = 1'b1;
        push(1'b1, t0 + 20);
        arm();
        wait_to(t0 + 22);
        check("lock_idle_state", int'(state_o), 0);
        wait_to(t0 + 120);
        check("q_lock", exp_q.size(), 0);

        sb_en = 1'b0;
        grounded = 1'b0;
        do_spawn();
        wait_drop("sync_mreset");
        grounded = 1'b1;
        push(1'b1, t0 + 28);
        arm();
        strobe_reset_at(t0 + 5);
        strobe_reset_at(t0 + 9);
        strobe_reset_at(t0 + 13);
        wait_to(t0 + 45);
        check("q_mreset", exp_q.size(), 0);
        check("mreset_idle_state", int'(state_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
